// File: rtl/ysyx_25060170_pkg.sv
// Shared encodings for the multi-cycle sequencer: RV32I opcodes,
// the ebreak word and the FSM state encoding.
package ysyx_25060170_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

endpackage

// File: rtl/ysyx_25060170_seq_dec.sv
// Opcode classifier for the sequencer: load/store/branch flags
// and the legal-opcode check.
module ysyx_25060170_seq_dec
  import ysyx_25060170_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       legal
);

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    legal     = 1'b1;
    unique case (1'b1)
      opcode == OP_LOAD:   is_load   = 1'b1;
      opcode == OP_STORE:  is_store  = 1'b1;
      opcode == OP_BRANCH: is_branch = 1'b1;
      opcode == OP_LUI,
      opcode == OP_AUIPC,
      opcode == OP_JAL,
      opcode == OP_JALR,
      opcode == OP_IMM,
      opcode == OP_REG:    legal     = 1'b1;
      default:             legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_seq.sv
// Multi-cycle control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT.
// Define YSYX_25060170_SEQ_PERF_EN to add cycle/instret counters.
module ysyx_25060170_seq
  import ysyx_25060170_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        ifu_rvalid_i,
  input  logic        lsu_done_i,
  output logic        ifu_req_o,
  output logic        ir_we_o,
  output logic        lsu_req_o,
  output logic        lsu_wen_o,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic        halt_o,
  output logic        illegal_o,
  output logic        fault_o,
`ifdef YSYX_25060170_SEQ_PERF_EN
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o,
`endif
  output logic [2:0]  state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_q, fault_q;
  logic            set_illegal, set_fault;
  logic            is_load, is_store, is_branch, legal;
  logic            last_wait;

  ysyx_25060170_seq_dec u_dec (
    .opcode    (inst_i[6:0]),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .legal     (legal)
  );

  // Final allowed wait cycle; a response in this cycle still wins.
  assign last_wait = (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_rvalid_i) begin
          state_d = S_DECODE;
        end else if (last_wait) begin
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end
      S_DECODE: begin
        if (inst_i == EBREAK) begin
          state_d = S_HALT;
        end else if (!legal) begin
          state_d     = S_HALT;
          set_illegal = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_done_i) begin
          state_d = S_WB;
        end else if (last_wait) begin
          state_d   = S_HALT;
          set_fault = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_FETCH || state_q == S_MEM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_q | set_illegal;
      fault_q   <= fault_q | set_fault;
    end
  end

  assign ifu_req_o = (state_q == S_FETCH);
  assign ir_we_o   = (state_q == S_FETCH) && ifu_rvalid_i;
  assign lsu_req_o = (state_q == S_MEM);
  assign lsu_wen_o = (state_q == S_MEM) && is_store;
  assign pc_we_o   = (state_q == S_WB);
  assign rf_we_o   = (state_q == S_WB) && !is_store && !is_branch;
  assign halt_o    = (state_q == S_HALT);
  assign illegal_o = illegal_q;
  assign fault_o   = fault_q;
  assign state_o   = state_q;

`ifdef YSYX_25060170_SEQ_PERF_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q <= cycle_q + 64'd1;
      if (state_q == S_WB) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;
`endif

endmodule
